hilo_muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller that owns the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU requests from the EX stage and sequences a one-bit-per-cycle shift-add / restoring-divide datapath over 32 iterations. It services MTHI/MTLO writes and MFHI/MFLO reads, and raises a stall to the hazard logic whenever the pipeline touches HI/LO or issues a new operation while a computation is in flight.

---
 rtl/hilo_muldiv_if.sv | 34 +++
 rtl/hilo_muldiv_sequencer.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_if
// Brief    : EX-stage request / HI-LO result bundle for the mul/div sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data, rd_hilo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data, rd_hilo,
    output hi, lo, busy, done, stall
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer
// Brief    : Iterative one-bit-per-cycle MULT/DIV engine owning HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst,
  hilo_muldiv_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               div_q, div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               busy;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      div_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (count_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand magnitudes, one iteration step, and sign fix-up
  always_comb begin
    a_neg    = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg    = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    div_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], rem_ge};

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    count_d    = count_q;
    div_d      = div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          div_d      = bus.op[1];
          sign_a_d   = a_neg;
          sign_b_d   = b_neg;
          div_zero_d = (bus.b == '0);
          count_d    = CNT_W'(WIDTH);
          // Multiply walks the multiplier through the low half; divide
          // shifts the dividend out of it.
          if (bus.op[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      S_CALC: begin
        count_d = count_q - CNT_W'(1);
        acc_d   = div_q ? div_next : mul_next;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (div_q) begin
          // Zero divisor leaves |A| in the remainder, so only LO is forced.
          hi_d = rem_fix;
          lo_d = div_zero_q ? '1 : quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    bus.busy  = busy;
    bus.stall = busy & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);
    bus.done  = done_q;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_sequencer
// Brief    : Scoreboard bench for the HI/LO mul/div sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(32)) bus ();
  hilo_muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned t0;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference {HI, LO} using native operators
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2, r;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    case (op)
      2'd0: begin r = sa * sb2; return r; end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        r = sa / sb2;
        sa = sa % sb2;
        return {sa[31:0], r[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    m = model(op, a, b);
    sb.push_back('{m[63:32], m[31:0], cyc});
  endtask

  // Leaves the caller at the negedge following the sampling edge E0
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push = 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    if (push) push_exp(op, a, b);
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_done(input int budget = 40);
    bit   seen = 1'b0;
    bit   gap  = 1'b0;
    int   n    = 0;
    exp_t e;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) gap = 1'b1;
    end
    check("busy_continuous", {63'd0, gap}, 64'd0);
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
      check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
      check("latency", 64'(cyc - e.t0), 64'd33);
    end
    check("busy_in_done", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);
  endtask

  logic [31:0] hold_hi, hold_lo;
  logic [1:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0; bus.rd_hilo = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_stall", {63'd0, bus.stall}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);

    issue(2'd0, 32'hFFFF_FFFD, 32'd5);            wait_done();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    wait_done();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);            wait_done();
    issue(2'd3, 32'h0000_1234, 32'd0);            wait_done();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);    wait_done();
    issue(2'd2, 32'hFFFF_FF00, 32'd0);            wait_done();

    // Requests raised while busy must stall and leave HI/LO untouched
    hold_hi = bus.hi; hold_lo = bus.lo;
    issue(2'd0, 32'h0000_1000, 32'hFFFF_FFFE);
    bus.rd_hilo = 1'b1; #1;
    check("stall_rd", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    bus.rd_hilo = 1'b0;
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd9; bus.b = 32'd9; #1;
    check("stall_start", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'hAA; #1;
    check("stall_wrlo", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    bus.wr_lo = 1'b0;
    check("hilo_hold", {bus.hi, bus.lo}, {hold_hi, hold_lo});
    wait_done();

    // IDLE MTHI/MTLO
    bus.wr_hi = 1'b1; bus.wr_data = 32'h55; #1;
    check("idle_wrhi_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h66; #1;
    check("mthi", {32'd0, bus.hi}, 64'h55);
    check("idle_wrlo_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    bus.wr_lo = 1'b0;
    check("mtlo", {bus.hi, bus.lo}, {32'h55, 32'h66});

    // Same-cycle Start + MTHI: write visible first, result overwrites later
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd3;
    bus.wr_hi = 1'b1; bus.wr_data = 32'h77;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    push_exp(2'd1, 32'd2, 32'd3);
    check("start_wrhi_visible", {32'd0, bus.hi}, 64'h77);
    check("start_wrhi_busy", {63'd0, bus.busy}, 64'd1);
    wait_done();

    // Reset part-way through a divide discards it
    issue(2'd2, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midreset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    issue(2'd0, 32'd7, 32'd6);                    wait_done();

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : $urandom;
      if (i == 2) rb = 32'd0 - 32'($urandom_range(1, 100));
      issue(rop, ra, rb);
      wait_done();
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
